// File: rtl/hs_arb_fifo.sv
// Multi-channel valid/ack arbiter feeding a first-word-fall-through FIFO.
// Each stored word carries the index of the channel that supplied it.
module hs_arb_fifo #(
  parameter int DWIDTH = 8,
  parameter int NCH    = 4,
  parameter int DEPTH  = 4,
  parameter int MODE   = 0,
  localparam int CHW   = $clog2(NCH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NCH-1:0]        in_vld,
  input  logic [NCH*DWIDTH-1:0] din,
  output logic [NCH-1:0]        in_ack,
  output logic                  out_vld,
  output logic [DWIDTH-1:0]     dout,
  output logic [CHW-1:0]        out_ch,
  input  logic                  out_ack,
  output logic [LW-1:0]         level,
  output logic                  full
);

  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem_data [DEPTH];
  logic [CHW-1:0]    mem_ch   [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CHW-1:0]    rr_ptr, grant;
  logic [CHW:0]      pos;
  logic              found, push, pop;

  // One spare bit in pos keeps rr_ptr + i from wrapping early when NCH is
  // not a power of two.
  // NOTE: combinational blocks use blocking assignments and give every
  // variable a default first, so no latch is inferred.
  always_comb begin
    found = 1'b0;
    grant = '0;
    pos   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (MODE == 0) begin
        pos = {1'b0, rr_ptr} + (CHW+1)'(i);
        if (pos >= (CHW+1)'(NCH)) pos = pos - (CHW+1)'(NCH);
      end else begin
        pos = (CHW+1)'(i);
      end
      if (!found && in_vld[pos[CHW-1:0]]) begin
        found = 1'b1;
        grant = pos[CHW-1:0];
      end
    end
  end

  assign in_ack  = (found && !full && !rst_i) ? (NCH'(1) << grant) : '0;
  assign push    = |in_ack;
  assign pop     = out_vld & out_ack;
  assign out_vld = (level != '0);
  assign full    = (level == LW'(DEPTH));
  assign dout    = mem_data[rd_ptr];
  assign out_ch  = mem_ch[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
      if (MODE == 0 && push)
        rr_ptr <= (grant == CHW'(NCH - 1)) ? '0 : grant + CHW'(1);
    end
  end

  // NOTE: storage is deliberately left out of reset; out_vld gates its use.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= din[int'(grant)*DWIDTH +: DWIDTH];
      mem_ch[wr_ptr]   <= grant;
    end
  end

endmodule

// File: tb/tb_hs_arb_fifo.sv
// Bench for hs_arb_fifo: one round-robin and one fixed-priority instance share
// stimulus; directed scenarios plus a random run against a queue-based model.
module tb_hs_arb_fifo;

  localparam int DW    = 8;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int CHW   = $clog2(NCH);
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef logic [CHW+DW-1:0] ent_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NCH-1:0]          in_vld;
  logic [NCH*DW-1:0]       din;
  logic                    out_ack;
  logic [1:0][NCH-1:0]     ack;
  logic [1:0]              ovld, fl;
  logic [1:0][DW-1:0]      dout;
  logic [1:0][CHW-1:0]     och;
  logic [1:0][LW-1:0]      lvl;

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 is round-robin, index 1 is fixed priority.
  ent_t mq [2][$];
  int   mrr;

  always #5 clk = ~clk;

  hs_arb_fifo #(.DWIDTH(DW), .NCH(NCH), .DEPTH(DEPTH), .MODE(0)) u_rr (
    .clk_i(clk), .rst_i(rst), .in_vld(in_vld), .din(din), .in_ack(ack[0]),
    .out_vld(ovld[0]), .dout(dout[0]), .out_ch(och[0]), .out_ack(out_ack),
    .level(lvl[0]), .full(fl[0]));

  hs_arb_fifo #(.DWIDTH(DW), .NCH(NCH), .DEPTH(DEPTH), .MODE(1)) u_fp (
    .clk_i(clk), .rst_i(rst), .in_vld(in_vld), .din(din), .in_ack(ack[1]),
    .out_vld(ovld[1]), .dout(dout[1]), .out_ch(och[1]), .out_ack(out_ack),
    .level(lvl[1]), .full(fl[1]));

  // Inputs change on the falling edge; outputs are observed 1 ns later.
  task automatic step(input logic r, input logic [NCH-1:0] v,
                      input logic [NCH*DW-1:0] d, input logic oa);
    @(negedge clk);
    rst = r; in_vld = v; din = d; out_ack = oa;
    #1;
  endtask

  function automatic logic [NCH*DW-1:0] lanes(int k, logic [DW-1:0] val);
    logic [NCH*DW-1:0] d;
    for (int i = 0; i < NCH; i++) d[i*DW +: DW] = DW'($urandom);
    d[k*DW +: DW] = val;
    return d;
  endfunction

  function automatic logic [NCH-1:0] exp_ack(int m, logic [NCH-1:0] v, logic r);
    logic [NCH-1:0] a;
    a = '0;
    if (r || mq[m].size() == DEPTH) return a;
    for (int i = 0; i < NCH; i++) begin
      int k;
      k = (m == 0) ? (mrr + i) % NCH : i;
      if (v[k]) begin
        a[k] = 1'b1;
        return a;
      end
    end
    return a;
  endfunction

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; in_vld = 4'b1111; din = lanes(0, 8'h00); out_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ack !== '0 || ovld !== 2'b00 || lvl !== '0 || fl !== 2'b00) begin
        errors++;
        $display("FAIL reset c%0d: ack=%h vld=%b lvl=%h full=%b, required all zero",
                 c, ack, ovld, lvl, fl);
      end
      @(negedge clk);
    end
    step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_single;
    step(1'b0, 4'b0100, lanes(2, 8'hA5), 1'b0);
    checks++;
    if (ack !== {4'b0100, 4'b0100}) begin
      errors++; $display("FAIL single_ack: got %h required 4,4", ack);
    end
    step(1'b0, '0, '0, 1'b0);
    checks++;
    if (ovld !== 2'b11 || dout !== {8'hA5, 8'hA5} || och !== {2'd2, 2'd2} ||
        lvl !== {LW'(1), LW'(1)}) begin
      errors++;
      $display("FAIL single_head: vld=%b dout=%h ch=%h lvl=%h required 11 a5a5 2,2 1,1",
               ovld, dout, och, lvl);
    end
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_arbitration;
    step(1'b1, '0, '0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [NCH-1:0] e0;
      e0 = NCH'(1) << (i % NCH);
      step(1'b0, 4'b1111, lanes(0, DW'(i)), 1'b1);
      checks++;
      if (ack !== {4'b0001, e0}) begin
        errors++;
        $display("FAIL arb_grant%0d: rr=%b fp=%b required rr=%b fp=0001",
                 i, ack[0], ack[1], e0);
      end
    end
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, '0, '0, 1'b0);
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b0001, lanes(0, 8'h10 + DW'(i)), 1'b0);
      checks++;
      if (ack !== {4'b0001, 4'b0001}) begin
        errors++; $display("FAIL fill_ack%0d: got %h required 1,1", i, ack);
      end
    end
    step(1'b0, 4'b0001, lanes(0, 8'h14), 1'b0);
    checks++;
    if (lvl !== {LW'(4), LW'(4)} || fl !== 2'b11 || ack !== '0) begin
      errors++;
      $display("FAIL full_state: lvl=%h full=%b ack=%h required 4,4 11 0", lvl, fl, ack);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b1);
      checks++;
      if (ovld !== 2'b11 || dout !== {8'h10 + DW'(i), 8'h10 + DW'(i)} || och !== '0) begin
        errors++;
        $display("FAIL drain%0d: vld=%b dout=%h ch=%h required %h", i, ovld, dout, och,
                 8'h10 + DW'(i));
      end
    end
    step(1'b0, '0, '0, 1'b1);
    checks++;
    if (lvl !== '0 || ovld !== 2'b00 || fl !== 2'b00) begin
      errors++; $display("FAIL drained: lvl=%h vld=%b full=%b required 0", lvl, ovld, fl);
    end
    step(1'b0, '0, '0, 1'b0);
    checks++;
    if (lvl !== '0 || ovld !== 2'b00) begin
      errors++; $display("FAIL empty_pop_ignored: lvl=%h vld=%b required 0", lvl, ovld);
    end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0010, lanes(1, 8'h20 + DW'(i)), 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, 4'b0010, lanes(1, 8'h77), 1'b1);
    checks++;
    if (ack !== {4'b0010, 4'b0010} || lvl !== {LW'(2), LW'(2)} ||
        dout !== {8'h21, 8'h21}) begin
      errors++;
      $display("FAIL simul_pre: ack=%h lvl=%h dout=%h required 2,2 2,2 21", ack, lvl, dout);
    end
    step(1'b0, 4'b0010, lanes(1, 8'h78), 1'b0);
    checks++;
    if (lvl !== {LW'(2), LW'(2)} || dout !== {8'h22, 8'h22}) begin
      errors++;
      $display("FAIL simul_level: lvl=%h dout=%h required 2,2 22", lvl, dout);
    end
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] e;
      e = (i == 0) ? 8'h22 : (i == 1) ? 8'h77 : 8'h78;
      step(1'b0, '0, '0, 1'b1);
      checks++;
      if (ovld !== 2'b11 || dout !== {e, e} || och !== {2'd1, 2'd1}) begin
        errors++;
        $display("FAIL wrap_order%0d: vld=%b dout=%h ch=%h required %h ch1",
                 i, ovld, dout, och, e);
      end
    end
    step(1'b0, '0, '0, 1'b0);
    checks++;
    if (lvl !== '0) begin
      errors++; $display("FAIL wrap_empty: lvl=%h required 0", lvl);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1000, lanes(3, 8'h31 + DW'(i)), 1'b0);
    step(1'b1, 4'b1000, lanes(3, 8'h99), 1'b0);
    checks++;
    if (ovld !== 2'b00 || lvl !== '0 || ack !== '0) begin
      errors++;
      $display("FAIL midreset: vld=%b lvl=%h ack=%h required 0", ovld, lvl, ack);
    end
    step(1'b0, 4'b1000, lanes(3, 8'h5A), 1'b0);
    checks++;
    if (ack !== {4'b1000, 4'b1000}) begin
      errors++; $display("FAIL post_reset_ack: got %h required 8,8", ack);
    end
    step(1'b0, '0, '0, 1'b0);
    checks++;
    if (ovld !== 2'b11 || dout !== {8'h5A, 8'h5A} || och !== {2'd3, 2'd3} ||
        lvl !== {LW'(1), LW'(1)}) begin
      errors++;
      $display("FAIL post_reset_head: vld=%b dout=%h ch=%h lvl=%h required 5a ch3 1",
               ovld, dout, och, lvl);
    end
  endtask

  task automatic test_random;
    step(1'b1, '0, '0, 1'b0);
    mq[0].delete(); mq[1].delete(); mrr = 0;
    for (int c = 0; c < 500; c++) begin
      logic           r;
      logic [NCH-1:0] ea;
      r = ($urandom_range(0, 59) == 0);
      step(r, NCH'($urandom), lanes(0, DW'($urandom)), 1'($urandom_range(0, 1)));
      if (r) begin
        mq[0].delete(); mq[1].delete(); mrr = 0;
      end
      for (int m = 0; m < 2; m++) begin
        ea = exp_ack(m, in_vld, rst);
        checks++;
        if (ack[m] !== ea || lvl[m] !== LW'(mq[m].size()) ||
            ovld[m] !== (mq[m].size() != 0) || fl[m] !== (mq[m].size() == DEPTH)) begin
          errors++;
          $display("FAIL rand_ctl c%0d m%0d: ack=%b lvl=%0d vld=%b full=%b required ack=%b lvl=%0d",
                   c, m, ack[m], lvl[m], ovld[m], fl[m], ea, mq[m].size());
        end
        if (mq[m].size() != 0) begin
          checks++;
          if ({och[m], dout[m]} !== mq[m][0]) begin
            errors++;
            $display("FAIL rand_head c%0d m%0d: got ch%0d/%h required %h",
                     c, m, och[m], dout[m], mq[m][0]);
          end
        end
        if (!rst) begin
          if (mq[m].size() != 0 && out_ack) void'(mq[m].pop_front());
          for (int k = 0; k < NCH; k++) begin
            if (ea[k]) begin
              mq[m].push_back({CHW'(k), din[k*DW +: DW]});
              if (m == 0) mrr = (k + 1) % NCH;
            end
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_vld = '0; din = '0; out_ack = 1'b0;
    test_reset();
    test_single();
    test_arbitration();
    test_fill_drain();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hs_arb_fifo.md
HS_ARB_FIFO -- requirements
Module: hs_arb_fifo

Interface
REQ-001 Parameter DWIDTH, default 8, width of one data word; legal range >= 1.
REQ-002 Parameter NCH, default 4, number of input channels; legal range >= 2.
REQ-003 Parameter DEPTH, default 4, number of FIFO entries; must be a power of 2 and >= 2.
REQ-004 Parameter MODE, default 0, selects arbitration: 0 = round-robin, 1 = fixed priority with channel 0 highest.
REQ-005 Derived widths: CHW = clog2(NCH); LW = clog2(DEPTH)+1.
REQ-006 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_i  input  1  reset, asynchronous and active-high.
REQ-008 in_vld  input  NCH  per-channel valid.
REQ-009 din  input  NCH*DWIDTH  channel k data occupies bits [k*DWIDTH +: DWIDTH].
REQ-010 in_ack  output  NCH  per-channel accept, combinational, one-hot or zero.
REQ-011 out_vld  output  1  FIFO head valid.
REQ-012 dout  output  DWIDTH  FIFO head data.
REQ-013 out_ch  output  CHW  source channel of the head word.
REQ-014 out_ack  input  1  consumer accept.
REQ-015 level  output  LW  current occupancy, range 0..DEPTH.
REQ-016 full  output  1  high when level == DEPTH.

Function
REQ-017 A transfer on channel k occurs in a cycle where in_vld[k] & in_ack[k]; an output transfer occurs where out_vld & out_ack.
REQ-018 in_ack SHALL be all-zero when full == 1 or rst_i == 1; in_ack has no combinational path from out_ack.
REQ-019 When not full and at least one in_vld bit is set, exactly one in_ack bit is set: the granted channel g.
REQ-020 MODE 0 grant: g is the first channel with in_vld set, searching from rr_ptr upward modulo NCH; on a transfer, rr_ptr <= (g+1) mod NCH; otherwise rr_ptr holds.
REQ-021 MODE 1 grant: g is the lowest-index channel with in_vld set; rr_ptr is unused.
REQ-022 On an input transfer, {g, din[g]} is written at wr_ptr and wr_ptr advances modulo DEPTH.
REQ-023 Output is first-word-fall-through: out_vld = (level != 0); dout and out_ch = entry at rd_ptr; all three are registered-state driven, with no combinational path from inputs.
REQ-024 Latency: a word accepted in cycle N appears on dout with out_vld = 1 in cycle N+1, given an empty FIFO.
REQ-025 On an output transfer, rd_ptr advances modulo DEPTH.
REQ-026 level update:
- push only: +1
- pop only: -1
- simultaneous push and pop: unchanged
REQ-027 out_ack while out_vld == 0 SHALL be ignored; it must not underflow level or move rd_ptr.
REQ-028 Words leave in exact acceptance order; pointer wrap from DEPTH-1 to 0 SHALL not corrupt order.
REQ-029 Senders hold din[k] stable while in_vld[k] & !in_ack[k]; the block need not tolerate violation.
REQ-030 An input whose in_vld drops before being acked SHALL leave no state change.

Reset
REQ-031 While rst_i is high, these SHALL hold: wr_ptr = rd_ptr = 0, level = 0, rr_ptr = 0, out_vld = 0, full = 0, in_ack = 0.
REQ-032 FIFO storage need not be reset; dout and out_ch are don't-care while out_vld = 0.
REQ-033 Reset asserted mid-operation discards all stored words immediately; after release, the first accepted word is the next output.

Verification (NCH=4, DEPTH=4, DWIDTH=8)
REQ-034 Assert rst_i with in_vld=4'b1111 -> in_ack=0, out_vld=0, level=0, full=0 throughout reset.
REQ-035 Empty FIFO; in_vld=4'b0100, din[2]=0xA5 for one cycle -> in_ack=4'b0100 that cycle; next cycle out_vld=1, dout=0xA5, out_ch=2, level=1.
REQ-036 MODE 0, in_vld=4'b1111 held, out_ack=1 -> grants in order ch0,1,2,3,0,1; MODE 1 same stimulus -> every grant ch0.
REQ-037 out_ack=0; ch0 pushes 0x10,0x11,0x12,0x13 -> level=4, full=1, in_ack=0 on a fifth push; then out_ack=1 for four cycles -> dout 0x10,0x11,0x12,0x13, level=0, out_vld=0.
REQ-038 level=2 with simultaneous push 0x77 and pop -> level stays 2; 0x77 emerges after the remaining older word; pointer wrap is exercised.
REQ-039 level=3, pulse rst_i for one cycle -> out_vld=0 and level=0 immediately; next push 0x5A -> dout=0x5A one cycle later.
